// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave memory: FSM state encoding,
// ACK/NACK bus levels and the byte width.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the asynchronous SCL/SDA pins and produces registered
// single-cycle SCL edge, START and STOP strobes plus the synchronised SDA.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d;
  logic sda_prev_q, sda_prev_d;
  logic scl_rise_q, scl_rise_d;
  logic scl_fall_q, scl_fall_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic sda_q, sda_d;
  logic scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Next-state for the synchroniser chains and the edge/condition strobes
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise_d = scl_s & ~scl_prev_q;
    scl_fall_d = ~scl_s & scl_prev_q;
    start_d    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    stop_d     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    sda_d      = sda_s;
  end

  // Registers; an idle bus (both lines high) is assumed out of reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_q      <= sda_d;
    end
  end

  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;
  assign sda       = sda_q;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C slave with an internal byte memory: address match, word pointer,
// auto-incrementing burst writes/reads, repeated START, open-drain SDA.
module i2c_mem_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned ADDR_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              addr_nack,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda_s)
  );

  i2c_state_t        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              ack_ph_q, ack_ph_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              addr_nack_q, addr_nack_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              mem_we;
  logic [BYTE_W-1:0] rx_byte, rd_byte;
  logic [BYTE_W-1:0] mem [MEM_DEPTH];

  // Protocol FSM; ack_ph marks that the 9th SCL rise of a byte has been seen
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_ph_d    = ack_ph_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    addr_nack_d = 1'b0;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    rx_byte     = {shift_q[BYTE_W-2:0], sda_s};
    rd_byte     = mem[ptr_q];
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          sda_oe_d  = 1'b0;
        end
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_ph_d = 1'b0;
              case (state_q)
                ST_ADDR: begin
                  if (rx_byte[BYTE_W-1:1] == DEV_ADDR) begin
                    state_d = ST_ADDR_ACK;
                    rw_d    = rx_byte[0];
                    busy_d  = 1'b1;
                  end else begin
                    state_d     = ST_IDLE;
                    addr_nack_d = 1'b1;
                    busy_d      = 1'b0;
                  end
                end
                ST_PTR: begin
                  ptr_d   = rx_byte[ADDR_W-1:0];
                  state_d = ST_PTR_ACK;
                end
                default: begin
                  mem_we     = 1'b1;
                  wr_pulse_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = rx_byte;
                  ptr_d      = ptr_q + ADDR_W'(1'b1);
                  state_d    = ST_WDATA_ACK;
                end
              endcase
            end else begin
              ack_ph_d = ack_ph_q;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (ack_ph_q) begin
              ack_ph_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if ((state_q == ST_ADDR_ACK) && rw_q) begin
                state_d  = ST_RDATA;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[BYTE_W-1];
              end else begin
                state_d  = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                sda_oe_d = 1'b0;
              end
            end else begin
              sda_oe_d = ~I2C_ACK;
            end
          end else if (scl_rise) begin
            ack_ph_d = 1'b1;
          end else begin
            ack_ph_d = ack_ph_q;
          end
        end
        // shift_q[7] always holds the bit to present on the next SCL fall
        ST_RDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d  = ST_RDATA_ACK;
              ack_ph_d = 1'b0;
            end else begin
              state_d = ST_RDATA;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[BYTE_W-1];
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (ack_ph_q) begin
              state_d   = ST_RDATA;
              shift_d   = rd_byte;
              sda_oe_d  = ~rd_byte[BYTE_W-1];
              ack_ph_d  = 1'b0;
              bit_cnt_d = 3'd0;
            end else begin
              ack_ph_d = 1'b0;
            end
          end else if (scl_rise) begin
            if (sda_s == I2C_NACK) begin
              state_d  = ST_IDLE;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end else begin
              ptr_d    = ptr_q + ADDR_W'(1'b1);
              ack_ph_d = 1'b1;
            end
          end else begin
            ack_ph_d = ack_ph_q;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_ph_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr_nack_q <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_ph_q    <= ack_ph_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      addr_nack_q <= addr_nack_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Memory array, deliberately without reset
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[ptr_q] <= rx_byte;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign addr_nack = addr_nack_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
